// File: rtl/fsm_mestre_linha.sv
// ---------------------------------------------------------------------------
// fsm_mestre_linha
// Master sequencer for the bottling line. Moves the conveyor between the
// fill, cap and quality-control stations and issues the command handshake to
// each station slave. Approved bottles are counted into dozens, and a station
// that stalls longer than TIMEOUT_CICLOS cycles drives the line into a
// latched fault that only reset clears.
//
// Ports
//   clk                   50 MHz clock
//   reset                 synchronous reset, active low
//   ligar                 line run switch
//   sensor_enchimento     bottle present at fill position
//   sensor_vedacao        bottle present at cap position
//   sensor_cq             bottle present at QC position
//   enchimento_concluido  fill slave done (held until cmd_encher drops)
//   vedacao_concluida     cap slave done (held until cmd_vedar drops)
//   cq_tarefa_concluida   QC slave approved-and-done
//   cq_descarte_ativo     QC slave discard in progress
//   motor_esteira         conveyor motor
//   cmd_encher            fill command
//   cmd_vedar             cap command
//   cmd_verificar         QC command
//   cont_garrafas         approved bottles in the current dozen (0..DUZIA-1)
//   cont_duzias           completed dozens, saturating at 255
//   duzia_completa        one-cycle pulse when a dozen completes
//   falha                 latched fault
//   estado_dbg            current state encoding
// ---------------------------------------------------------------------------
module fsm_mestre_linha #(
  parameter logic [26:0] TIMEOUT_CICLOS = 27'd100000000,
  parameter logic [3:0]  DUZIA          = 4'd12
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ligar,
  input  logic       sensor_enchimento,
  input  logic       sensor_vedacao,
  input  logic       sensor_cq,
  input  logic       enchimento_concluido,
  input  logic       vedacao_concluida,
  input  logic       cq_tarefa_concluida,
  input  logic       cq_descarte_ativo,
  output logic       motor_esteira,
  output logic       cmd_encher,
  output logic       cmd_vedar,
  output logic       cmd_verificar,
  output logic [3:0] cont_garrafas,
  output logic [7:0] cont_duzias,
  output logic       duzia_completa,
  output logic       falha,
  output logic [3:0] estado_dbg
);

  typedef enum logic [3:0] {
    IDLE            = 4'd0,
    AVANCA_ENCH     = 4'd1,
    ENCHENDO        = 4'd2,
    LIBERA_ENCH     = 4'd3,
    AVANCA_VED      = 4'd4,
    VEDANDO         = 4'd5,
    LIBERA_VED      = 4'd6,
    AVANCA_CQ       = 4'd7,
    VERIFICANDO     = 4'd8,
    APROVADO_ACK    = 4'd9,
    DESCARTE_ESPERA = 4'd10,
    PROXIMA         = 4'd11,
    FALHA           = 4'd12
  } estado_t;

  estado_t     state_reg, state_next;
  logic [26:0] timer_reg, timer_next;
  logic [3:0]  cont_garrafas_reg, cont_garrafas_next;
  logic [7:0]  cont_duzias_reg, cont_duzias_next;
  logic        duzia_completa_reg, duzia_completa_next;
  logic        motor_reg, motor_next;
  logic        cmd_encher_reg, cmd_encher_next;
  logic        cmd_vedar_reg, cmd_vedar_next;
  logic        cmd_verificar_reg, cmd_verificar_next;
  logic        falha_reg, falha_next;
  logic        timed_state;
  logic        entering_ack;

  // Next state, timer, counters and output decode
  always_comb begin
    state_next          = state_reg;
    timer_next          = '0;
    cont_garrafas_next  = cont_garrafas_reg;
    cont_duzias_next    = cont_duzias_reg;
    duzia_completa_next = 1'b0;
    timed_state         = 1'b1;
    entering_ack        = 1'b0;

    case (state_reg)
      IDLE: begin
        timed_state = 1'b0;
        if (ligar) state_next = AVANCA_ENCH;
      end
      AVANCA_ENCH:     if (sensor_enchimento)     state_next = ENCHENDO;
      ENCHENDO:        if (enchimento_concluido)  state_next = LIBERA_ENCH;
      LIBERA_ENCH:     if (!enchimento_concluido) state_next = AVANCA_VED;
      AVANCA_VED:      if (sensor_vedacao)        state_next = VEDANDO;
      VEDANDO:         if (vedacao_concluida)     state_next = LIBERA_VED;
      LIBERA_VED:      if (!vedacao_concluida)    state_next = AVANCA_CQ;
      AVANCA_CQ:       if (sensor_cq)             state_next = VERIFICANDO;
      VERIFICANDO: begin
        // Approval wins when the slave reports both at once
        if (cq_tarefa_concluida)    state_next = APROVADO_ACK;
        else if (cq_descarte_ativo) state_next = DESCARTE_ESPERA;
      end
      APROVADO_ACK:    if (!cq_tarefa_concluida)  state_next = PROXIMA;
      DESCARTE_ESPERA: if (!cq_descarte_ativo)    state_next = PROXIMA;
      PROXIMA: begin
        timed_state = 1'b0;
        state_next  = ligar ? AVANCA_ENCH : IDLE;
      end
      FALHA: begin
        timed_state = 1'b0;
      end
      default: begin
        // Unreachable encodings are treated as a fault
        timed_state = 1'b0;
        state_next  = FALHA;
      end
    endcase

    // A stall only becomes a fault when no exit condition fired this cycle
    if (timed_state && (state_next == state_reg) &&
        (timer_reg == TIMEOUT_CICLOS - 27'd1)) begin
      state_next = FALHA;
    end

    if (timed_state && (state_next == state_reg)) begin
      timer_next = timer_reg + 27'd1;
    end

    entering_ack = (state_reg == VERIFICANDO) && (state_next == APROVADO_ACK);
    if (entering_ack) begin
      if (cont_garrafas_reg == DUZIA - 4'd1) begin
        cont_garrafas_next  = 4'd0;
        duzia_completa_next = 1'b1;
        if (cont_duzias_reg != 8'hFF) begin
          cont_duzias_next = cont_duzias_reg + 8'd1;
        end
      end else begin
        cont_garrafas_next = cont_garrafas_reg + 4'd1;
      end
    end

    // Moore outputs decoded from the present state, registered below,
    // so they follow the state register by one cycle
    motor_next         = (state_reg == AVANCA_ENCH) || (state_reg == AVANCA_VED) ||
                         (state_reg == AVANCA_CQ);
    cmd_encher_next    = (state_reg == ENCHENDO);
    cmd_vedar_next     = (state_reg == VEDANDO);
    cmd_verificar_next = (state_reg == VERIFICANDO);
    falha_next         = (state_reg == FALHA);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg          <= IDLE;
      timer_reg          <= '0;
      cont_garrafas_reg  <= '0;
      cont_duzias_reg    <= '0;
      duzia_completa_reg <= 1'b0;
      motor_reg          <= 1'b0;
      cmd_encher_reg     <= 1'b0;
      cmd_vedar_reg      <= 1'b0;
      cmd_verificar_reg  <= 1'b0;
      falha_reg          <= 1'b0;
    end else begin
      state_reg          <= state_next;
      timer_reg          <= timer_next;
      cont_garrafas_reg  <= cont_garrafas_next;
      cont_duzias_reg    <= cont_duzias_next;
      duzia_completa_reg <= duzia_completa_next;
      motor_reg          <= motor_next;
      cmd_encher_reg     <= cmd_encher_next;
      cmd_vedar_reg      <= cmd_vedar_next;
      cmd_verificar_reg  <= cmd_verificar_next;
      falha_reg          <= falha_next;
    end
  end

  assign motor_esteira  = motor_reg;
  assign cmd_encher     = cmd_encher_reg;
  assign cmd_vedar      = cmd_vedar_reg;
  assign cmd_verificar  = cmd_verificar_reg;
  assign cont_garrafas  = cont_garrafas_reg;
  assign cont_duzias    = cont_duzias_reg;
  assign duzia_completa = duzia_completa_reg;
  assign falha          = falha_reg;
  // Debug view is the live state register, not the delayed decode
  assign estado_dbg     = state_reg;

endmodule

// File: tb/tb_fsm_mestre_linha.sv
// ---------------------------------------------------------------------------
// tb_fsm_mestre_linha
// Directed bench for the bottling line master sequencer. Inputs change and
// outputs are sampled on the falling clock edge; the DUT acts on the rising
// edge. The timeout is shortened to 20 cycles.
// ---------------------------------------------------------------------------
module tb_fsm_mestre_linha;

  localparam logic [26:0] TMO = 27'd20;

  logic       clk = 1'b0;
  logic       reset;
  logic       ligar;
  logic       sensor_enchimento;
  logic       sensor_vedacao;
  logic       sensor_cq;
  logic       enchimento_concluido;
  logic       vedacao_concluida;
  logic       cq_tarefa_concluida;
  logic       cq_descarte_ativo;
  logic       motor_esteira;
  logic       cmd_encher;
  logic       cmd_vedar;
  logic       cmd_verificar;
  logic [3:0] cont_garrafas;
  logic [7:0] cont_duzias;
  logic       duzia_completa;
  logic       falha;
  logic [3:0] estado_dbg;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fsm_mestre_linha #(
    .TIMEOUT_CICLOS(TMO),
    .DUZIA(4'd12)
  ) dut (
    .clk(clk),
    .reset(reset),
    .ligar(ligar),
    .sensor_enchimento(sensor_enchimento),
    .sensor_vedacao(sensor_vedacao),
    .sensor_cq(sensor_cq),
    .enchimento_concluido(enchimento_concluido),
    .vedacao_concluida(vedacao_concluida),
    .cq_tarefa_concluida(cq_tarefa_concluida),
    .cq_descarte_ativo(cq_descarte_ativo),
    .motor_esteira(motor_esteira),
    .cmd_encher(cmd_encher),
    .cmd_vedar(cmd_vedar),
    .cmd_verificar(cmd_verificar),
    .cont_garrafas(cont_garrafas),
    .cont_duzias(cont_duzias),
    .duzia_completa(duzia_completa),
    .falha(falha),
    .estado_dbg(estado_dbg)
  );

  task automatic step();
    @(negedge clk);
  endtask

  task automatic steps(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clear_inputs();
    sensor_enchimento    = 1'b0;
    sensor_vedacao       = 1'b0;
    sensor_cq            = 1'b0;
    enchimento_concluido = 1'b0;
    vedacao_concluida    = 1'b0;
    cq_tarefa_concluida  = 1'b0;
    cq_descarte_ativo    = 1'b0;
  endtask

  // Fill (which=0) or cap (which=1) station. Entered at a falling edge in the
  // AVANCA state with the motor on; leaves in the next AVANCA state with the
  // motor on. 'delay' extra cycles are spent in AVANCA before the sensor rises.
  task automatic run_station(input int which, input int delay, input bit drop);
    logic [3:0] base;
    logic       cmd;
    base = (which == 0) ? 4'd1 : 4'd4;
    steps(delay);
    if (which == 0) sensor_enchimento = 1'b1;
    else            sensor_vedacao    = 1'b1;
    step();
    checks++;
    if (estado_dbg !== base + 4'd1) begin
      errors++;
      $display("FAIL st%0d_enter_work: estado_dbg=%0d expected %0d", which, estado_dbg, base + 4'd1);
    end
    sensor_enchimento = 1'b0;
    sensor_vedacao    = 1'b0;
    if (drop) ligar = 1'b0;
    step();
    cmd = (which == 0) ? cmd_encher : cmd_vedar;
    checks++;
    if ({cmd, motor_esteira} !== 2'b10) begin
      errors++;
      $display("FAIL st%0d_cmd_on: cmd=%0b motor=%0b expected cmd=1 motor=0", which, cmd, motor_esteira);
    end
    if (which == 0) enchimento_concluido = 1'b1;
    else            vedacao_concluida    = 1'b1;
    step();
    checks++;
    if (estado_dbg !== base + 4'd2) begin
      errors++;
      $display("FAIL st%0d_enter_libera: estado_dbg=%0d expected %0d", which, estado_dbg, base + 4'd2);
    end
    enchimento_concluido = 1'b0;
    vedacao_concluida    = 1'b0;
    step();
    cmd = (which == 0) ? cmd_encher : cmd_vedar;
    checks++;
    if ({estado_dbg, cmd, motor_esteira} !== {base + 4'd3, 2'b00}) begin
      errors++;
      $display("FAIL st%0d_cmd_off: estado_dbg=%0d cmd=%0b motor=%0b expected estado=%0d cmd=0 motor=0",
               which, estado_dbg, cmd, motor_esteira, base + 4'd3);
    end
    step();
    checks++;
    if ({estado_dbg, motor_esteira} !== {base + 4'd3, 1'b1}) begin
      errors++;
      $display("FAIL st%0d_motor_resume: estado_dbg=%0d motor=%0b expected estado=%0d motor=1",
               which, estado_dbg, motor_esteira, base + 4'd3);
    end
  endtask

  // QC station with approval, from AVANCA_CQ (motor on) to PROXIMA
  task automatic run_qc(input logic [3:0] exp_cont);
    sensor_cq = 1'b1;
    step();
    checks++;
    if (estado_dbg !== 4'd8) begin
      errors++;
      $display("FAIL qc_enter: estado_dbg=%0d expected 8", estado_dbg);
    end
    sensor_cq = 1'b0;
    step();
    checks++;
    if ({cmd_verificar, motor_esteira} !== 2'b10) begin
      errors++;
      $display("FAIL qc_cmd_on: cmd_verificar=%0b motor=%0b expected 1 0", cmd_verificar, motor_esteira);
    end
    cq_tarefa_concluida = 1'b1;
    step();
    checks++;
    if ({estado_dbg, cont_garrafas} !== {4'd9, exp_cont}) begin
      errors++;
      $display("FAIL qc_approve: estado_dbg=%0d cont_garrafas=%0d expected 9 %0d", estado_dbg, cont_garrafas, exp_cont);
    end
    cq_tarefa_concluida = 1'b0;
    step();
    checks++;
    if ({estado_dbg, cmd_verificar} !== {4'd11, 1'b0}) begin
      errors++;
      $display("FAIL qc_release: estado_dbg=%0d cmd_verificar=%0b expected 11 0", estado_dbg, cmd_verificar);
    end
  endtask

  // Back-to-back approved bottles with slaves answering in one cycle
  task automatic run_fast(input int n, output int acks, output int pulses);
    int st;
    acks   = 0;
    pulses = 0;
    ligar             = 1'b1;
    sensor_enchimento = 1'b1;
    sensor_vedacao    = 1'b1;
    sensor_cq         = 1'b1;
    cq_descarte_ativo = 1'b0;
    for (int cyc = 0; cyc < n * 12 + 40; cyc++) begin
      @(negedge clk);
      st = int'(estado_dbg);
      if (duzia_completa) pulses++;
      if (st == 9) acks++;
      if (acks == n && st == 11) break;
      enchimento_concluido = (st == 2);
      vedacao_concluida    = (st == 5);
      cq_tarefa_concluida  = (st == 8);
    end
    checks++;
    if (acks != n) begin
      errors++;
      $display("FAIL fast_run_budget: approvals=%0d expected %0d", acks, n);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    ligar = 1'b1;
    sensor_enchimento    = 1'b1;
    sensor_vedacao       = 1'b1;
    sensor_cq            = 1'b1;
    enchimento_concluido = 1'b1;
    vedacao_concluida    = 1'b1;
    cq_tarefa_concluida  = 1'b1;
    cq_descarte_ativo    = 1'b1;
    steps(3);
    checks++;
    if ({motor_esteira, cmd_encher, cmd_vedar, cmd_verificar, cont_garrafas, cont_duzias,
         duzia_completa, falha, estado_dbg} !== 24'd0) begin
      errors++;
      $display("FAIL reset_outputs: motor=%0b enc=%0b ved=%0b ver=%0b garrafas=%0d duzias=%0d pulse=%0b falha=%0b estado=%0d expected all 0",
               motor_esteira, cmd_encher, cmd_vedar, cmd_verificar, cont_garrafas, cont_duzias,
               duzia_completa, falha, estado_dbg);
    end
    reset = 1'b1;
    clear_inputs();
    step();
    checks++;
    if ({estado_dbg, motor_esteira} !== {4'd1, 1'b0}) begin
      errors++;
      $display("FAIL reset_release: estado_dbg=%0d motor=%0b expected 1 0", estado_dbg, motor_esteira);
    end
    step();
    checks++;
    if ({estado_dbg, motor_esteira} !== {4'd1, 1'b1}) begin
      errors++;
      $display("FAIL first_motor: estado_dbg=%0d motor=%0b expected 1 1", estado_dbg, motor_esteira);
    end
  endtask

  task automatic next_bottle();
    step();
    checks++;
    if (estado_dbg !== 4'd1) begin
      errors++;
      $display("FAIL proxima_to_avanca: estado_dbg=%0d expected 1", estado_dbg);
    end
    step();
  endtask

  task automatic test_approved();
    run_station(0, 0, 1'b0);
    run_station(1, 0, 1'b0);
    run_qc(4'd1);
    next_bottle();
  endtask

  task automatic test_rejected();
    run_station(0, 0, 1'b0);
    run_station(1, 0, 1'b0);
    sensor_cq = 1'b1;
    step();
    sensor_cq = 1'b0;
    step();
    cq_descarte_ativo = 1'b1;
    step();
    checks++;
    if (estado_dbg !== 4'd10) begin
      errors++;
      $display("FAIL reject_enter: estado_dbg=%0d expected 10", estado_dbg);
    end
    step();
    checks++;
    if (cmd_verificar !== 1'b0) begin
      errors++;
      $display("FAIL reject_cmd_drop: cmd_verificar=%0b expected 0", cmd_verificar);
    end
    steps(8);
    checks++;
    if (estado_dbg !== 4'd10) begin
      errors++;
      $display("FAIL reject_hold: estado_dbg=%0d expected 10", estado_dbg);
    end
    cq_descarte_ativo = 1'b0;
    step();
    checks++;
    if ({estado_dbg, cont_garrafas} !== {4'd11, 4'd1}) begin
      errors++;
      $display("FAIL reject_done: estado_dbg=%0d cont_garrafas=%0d expected 11 1", estado_dbg, cont_garrafas);
    end
    next_bottle();
  endtask

  task automatic test_ligar_drop();
    run_station(0, 0, 1'b0);
    run_station(1, 0, 1'b1);
    run_qc(4'd2);
    for (int i = 0; i < 5; i++) begin
      step();
      checks++;
      if ({estado_dbg, motor_esteira} !== {4'd0, 1'b0}) begin
        errors++;
        $display("FAIL ligar_drop_idle[%0d]: estado_dbg=%0d motor=%0b expected 0 0", i, estado_dbg, motor_esteira);
      end
    end
    ligar = 1'b1;
    next_bottle();
  endtask

  task automatic test_timeout();
    // Sensor arrives exactly on the last allowed cycle: exit beats timeout
    run_station(0, 0, 1'b0);
    run_station(1, 18, 1'b0);
    run_qc(4'd3);
    next_bottle();
    sensor_enchimento = 1'b1;
    step();
    sensor_enchimento = 1'b0;
    steps(19);
    checks++;
    if (estado_dbg !== 4'd2) begin
      errors++;
      $display("FAIL timeout_early: estado_dbg=%0d expected 2", estado_dbg);
    end
    step();
    checks++;
    if ({estado_dbg, falha} !== {4'd12, 1'b0}) begin
      errors++;
      $display("FAIL timeout_enter: estado_dbg=%0d falha=%0b expected 12 0", estado_dbg, falha);
    end
    step();
    checks++;
    if ({falha, motor_esteira, cmd_encher, cmd_vedar, cmd_verificar} !== 5'b10000) begin
      errors++;
      $display("FAIL timeout_falha: falha=%0b motor=%0b enc=%0b ved=%0b ver=%0b expected 1 0 0 0 0",
               falha, motor_esteira, cmd_encher, cmd_vedar, cmd_verificar);
    end
    sensor_enchimento    = 1'b1;
    enchimento_concluido = 1'b1;
    for (int i = 0; i < 6; i++) begin
      ligar = ~ligar;
      step();
      checks++;
      if ({estado_dbg, falha, motor_esteira} !== {4'd12, 1'b1, 1'b0}) begin
        errors++;
        $display("FAIL falha_latched[%0d]: estado_dbg=%0d falha=%0b motor=%0b expected 12 1 0",
                 i, estado_dbg, falha, motor_esteira);
      end
    end
    clear_inputs();
    ligar = 1'b0;
    reset = 1'b0;
    step();
    checks++;
    if ({falha, estado_dbg, cont_garrafas} !== {1'b0, 4'd0, 4'd0}) begin
      errors++;
      $display("FAIL falha_reset: falha=%0b estado_dbg=%0d cont_garrafas=%0d expected 0 0 0",
               falha, estado_dbg, cont_garrafas);
    end
    reset = 1'b1;
  endtask

  task automatic test_reset_mid();
    ligar = 1'b1;
    step();
    sensor_enchimento = 1'b1;
    step();
    sensor_enchimento = 1'b0;
    step();
    checks++;
    if (cmd_encher !== 1'b1) begin
      errors++;
      $display("FAIL mid_cmd_on: cmd_encher=%0b expected 1", cmd_encher);
    end
    reset = 1'b0;
    step();
    checks++;
    if ({cmd_encher, estado_dbg, motor_esteira} !== {1'b0, 4'd0, 1'b0}) begin
      errors++;
      $display("FAIL mid_reset_abort: cmd_encher=%0b estado_dbg=%0d motor=%0b expected 0 0 0",
               cmd_encher, estado_dbg, motor_esteira);
    end
    reset = 1'b1;
  endtask

  task automatic test_back_to_back();
    int acks;
    int pulses;
    run_fast(3048, acks, pulses);
    checks++;
    if ({cont_duzias, cont_garrafas} !== {8'd254, 4'd0} || pulses != 254) begin
      errors++;
      $display("FAIL preload_254: duzias=%0d garrafas=%0d pulses=%0d expected 254 0 254",
               cont_duzias, cont_garrafas, pulses);
    end
    run_fast(11, acks, pulses);
    checks++;
    if ({cont_duzias, cont_garrafas} !== {8'd254, 4'd11} || pulses != 0) begin
      errors++;
      $display("FAIL eleven_more: duzias=%0d garrafas=%0d pulses=%0d expected 254 11 0",
               cont_duzias, cont_garrafas, pulses);
    end
    run_fast(1, acks, pulses);
    checks++;
    if ({cont_duzias, cont_garrafas} !== {8'd255, 4'd0} || pulses != 1) begin
      errors++;
      $display("FAIL dozen_255: duzias=%0d garrafas=%0d pulses=%0d expected 255 0 1",
               cont_duzias, cont_garrafas, pulses);
    end
    run_fast(12, acks, pulses);
    checks++;
    if ({cont_duzias, cont_garrafas} !== {8'd255, 4'd0} || pulses != 1) begin
      errors++;
      $display("FAIL dozen_saturated: duzias=%0d garrafas=%0d pulses=%0d expected 255 0 1",
               cont_duzias, cont_garrafas, pulses);
    end
  endtask

  initial begin
    clear_inputs();
    test_reset();
    test_approved();
    test_rejected();
    test_ligar_drop();
    test_timeout();
    test_reset_mid();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule

// File: doc/fsm_mestre_linha.md
Name: fsm_mestre_linha

Overview:
Master sequencer for the bottling line. Drives the conveyor and issues the per-station command handshakes: fill, cap, and quality control (initiator side of the QC/discard slave's cmd_verificar / tarefa_concluida / descarte_ativo interface). It counts approved bottles into dozens and enters a latched fault state if any station stalls.

Parameters:
TIMEOUT_CICLOS, 27'd100000000, maximum cycles in any wait state before fault (2 s at 50 MHz)
DUZIA, 4'd12, approved bottles per dozen

Ports:
clk  in  1  50 MHz clock
reset  in  1  synchronous, active-low reset (asserted when 0)
ligar  in  1  line run switch
sensor_enchimento  in  1  bottle at fill position
sensor_vedacao  in  1  bottle at cap position
sensor_cq  in  1  bottle at QC position
enchimento_concluido  in  1  fill slave done (held until cmd_encher drops)
vedacao_concluida  in  1  cap slave done (held until cmd_vedar drops)
cq_tarefa_concluida  in  1  QC slave approved-and-done
cq_descarte_ativo  in  1  QC slave discard in progress
motor_esteira  out  1  conveyor motor
cmd_encher  out  1  fill command
cmd_vedar  out  1  cap command
cmd_verificar  out  1  QC command
cont_garrafas  out  4  approved bottles in current dozen, 0..11
cont_duzias  out  8  completed dozens, saturates at 255
duzia_completa  out  1  one-cycle pulse on dozen completion
falha  out  1  latched fault
estado_dbg  out  4  current state encoding

Behaviour:
- Reset (reset==0 at posedge clk): state IDLE; timer, cont_garrafas, cont_duzias cleared. All outputs 0 on the same edge. Reset applied mid-operation aborts immediately and drops all commands.
- Moore outputs, registered. Each output reflects the state one cycle after the state register changes.
- States, with their encoding and the outputs asserted in each state:
  - IDLE (0): no outputs asserted. If ligar, go to AVANCA_ENCH.
  - AVANCA_ENCH (1): motor_esteira. If sensor_enchimento, go to ENCHENDO.
  - ENCHENDO (2): cmd_encher. If enchimento_concluido, go to LIBERA_ENCH.
  - LIBERA_ENCH (3): no outputs asserted. If !enchimento_concluido, go to AVANCA_VED.
  - AVANCA_VED (4), VEDANDO (5), LIBERA_VED (6): same pattern using sensor_vedacao, cmd_vedar and vedacao_concluida.
  - AVANCA_CQ (7): motor_esteira. If sensor_cq, go to VERIFICANDO.
  - VERIFICANDO (8): cmd_verificar.
    - If cq_tarefa_concluida, go to APROVADO_ACK.
    - Else if cq_descarte_ativo, go to DESCARTE_ESPERA.
    - If both are high, approval has priority.
  - APROVADO_ACK (9): no outputs asserted. Counter update happens on the entry edge. If !cq_tarefa_concluida, go to PROXIMA.
  - DESCARTE_ESPERA (10): cmd_verificar is low so the slave does not re-arm after its discard completes. If !cq_descarte_ativo, go to PROXIMA. No count.
  - PROXIMA (11): no outputs asserted. If ligar, go to AVANCA_ENCH; else go to IDLE.
  - FALHA (12): falha=1, all other outputs 0. Exit only by reset.
- ligar dropping mid-cycle does not abort the cycle: the current bottle finishes, then the FSM returns to IDLE at PROXIMA.
- Timeout:
  - 27-bit timer clears on every state change and in IDLE, PROXIMA and FALHA; it increments in every other state.
  - When timer==TIMEOUT_CICLOS-1 and no exit condition is true that cycle, go to FALHA.
  - An exit condition on the same cycle wins.
- Counting, on the transition into APROVADO_ACK:
  - If cont_garrafas==DUZIA-1: cont_garrafas←0, cont_duzias←cont_duzias+1 (held at 255 if already 255), and duzia_completa=1 for exactly one cycle.
  - Otherwise cont_garrafas←cont_garrafas+1.
  - The pulse is still generated when cont_duzias is saturated.

Test Plan:
- Reset held low for 3 cycles with ligar=1 and all sensors=1 -> all outputs 0 and estado_dbg=0; after release, AVANCA_ENCH is reached on the first edge.
- Approved bottle: full handshake sequence with cq_tarefa_concluida=1 -> cmd_encher, cmd_vedar and cmd_verificar each rise then fall in order; cont_garrafas 0→1; motor is off during each command.
- Rejected bottle: cq_descarte_ativo high for 10 cycles -> cmd_verificar drops within 2 cycles of descarte rising; cont_garrafas unchanged; PROXIMA is reached after descarte falls.
- 12 approvals starting from cont_duzias=254, then 12 more -> first dozen gives cont_duzias=255 with a single duzia_completa pulse; second dozen keeps cont_duzias=255 with a pulse, and cont_garrafas returns to 0.
- TIMEOUT_CICLOS=20 with enchimento_concluido held 0 in ENCHENDO -> falha=1 after 20 cycles in ENCHENDO; ligar toggling has no effect; reset clears falha.
- ligar dropped during VEDANDO -> the cycle completes, returns to IDLE, and motor stays 0 afterwards.
